// File: rtl/im_loader_pkg.sv
// Shared boot-loader constants: state encodings and the instruction fetch base.
package im_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'h0000_3000;
    localparam int unsigned DEPTH_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/im_loader_word_packer.sv
// Assembles payload bytes MSB first into a 32-bit word and flags the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // The completed word includes the byte being accepted this cycle.
    assign o_word = {r_shift, i_byte};
    assign o_last = i_valid && (r_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot loader: parses LEN_HI/LEN_LO/payload/checksum stream, writes words from
// BASE_ADDR and releases the CPU only after a matching checksum.
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    state_e      r_state;
    logic        r_rx_ready;
    logic        r_we;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_len_hi;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [7:0]  r_sum;

    logic        w_xfer;
    logic        w_data_xfer;
    logic [15:0] w_len;
    logic        w_len_big;
    logic        w_last_word;
    logic [31:0] w_word;
    logic        w_word_done;

    always_comb begin
        w_xfer      = rx_valid && r_rx_ready;
        w_data_xfer = w_xfer && (r_state == ST_DATA);
        w_len       = {r_len_hi, rx_data};
        w_len_big   = {16'd0, w_len} > DEPTH_WORDS;
        w_last_word = (r_idx == (r_len - 16'd1));
    end

    word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state == ST_LEN_HI),
        .i_valid (w_data_xfer),
        .i_byte  (rx_data),
        .o_word  (w_word),
        .o_last  (w_word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_LEN_HI;
            r_rx_ready <= 1'b1;
            r_we       <= 1'b0;
            r_waddr    <= BASE_ADDR;
            r_wdata    <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len_hi   <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_LEN_HI: begin
                    r_sum <= '0;
                    r_idx <= '0;
                    if (w_xfer) begin
                        r_len_hi <= rx_data;
                        r_state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == 16'd0) begin
                            r_state <= ST_CHECK;
                        end else if (w_len_big) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_sum <= r_sum + rx_data;
                        if (w_word_done) begin
                            r_we    <= 1'b1;
                            r_waddr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                            r_wdata <= w_word;
                            r_idx   <= r_idx + 16'd1;
                            if (w_last_word) begin
                                r_state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_sum) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_rx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: images are built as word lists and expected
// writes/outcome are derived from the stream rules.
module tb_im_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] img_words[$];
    logic [63:0] cap_q[$];
    bit          b2b_seen;
    logic        prev_we;

    always #5 clk = ~clk;

    im_loader #(.BASE_ADDR(32'h0000_3000), .DEPTH_WORDS(4096)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (we === 1'b1) begin
                cap_q.push_back({waddr, wdata});
                if (prev_we === 1'b1) b2b_seen = 1'b1;
            end
            prev_we = we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cap_q.delete();
        b2b_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        int cyc;
        bit ok;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 50) begin
            if (rx_ready === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        @(posedge clk);
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1 within 50 cycles", rx_ready);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Streams img_words as a full image and checks writes and final status.
    task automatic run_image(input string name, input bit bad_ck, input int gap_max);
        logic [7:0]  ck;
        logic [15:0] n16;
        logic [31:0] w;
        logic [63:0] exp_w;
        int n;
        n   = img_words.size();
        n16 = 16'(n);
        ck  = 8'h00;
        foreach (img_words[i]) begin
            w = img_words[i];
            ck = ck + w[31:24] + w[23:16] + w[15:8] + w[7:0];
        end
        if (bad_ck) ck = ck + 8'h01;
        cap_q.delete();
        b2b_seen = 1'b0;
        send_byte(n16[15:8], gap_max);
        send_byte(n16[7:0], gap_max);
        foreach (img_words[i]) begin
            w = img_words[i];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap_max);
        end
        send_byte(ck, gap_max);
        #1;
        n_checks++;
        if (done !== !bad_ck) begin
            n_errors++;
            $display("FAIL %s done: got %b want %b", name, done, !bad_ck);
        end
        n_checks++;
        if (err !== bad_ck) begin
            n_errors++;
            $display("FAIL %s err: got %b want %b", name, err, bad_ck);
        end
        n_checks++;
        if (cpu_hold !== bad_ck) begin
            n_errors++;
            $display("FAIL %s cpu_hold: got %b want %b", name, cpu_hold, bad_ck);
        end
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s rx_ready: got %b want 0", name, rx_ready);
        end
        idle(3);
        n_checks++;
        if (cap_q.size() != n) begin
            n_errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, cap_q.size(), n);
        end
        foreach (img_words[i]) begin
            exp_w = {BASE + 32'(4 * i), img_words[i]};
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_w) begin
                n_errors++;
                $display("FAIL %s write[%0d]: got %h want %h", name, i,
                         (i < cap_q.size()) ? cap_q[i] : 64'hx, exp_w);
            end
        end
        n_checks++;
        if (b2b_seen) begin
            n_errors++;
            $display("FAIL %s we_back_to_back: got 1 want 0", name);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({rx_ready, we, cpu_hold, done, err} !== 5'b10100) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 10100", {rx_ready, we, cpu_hold, done, err});
        end
        n_checks++;
        if (waddr !== BASE || wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_addr_data: got %h/%h want %h/0", waddr, wdata, BASE);
        end
    endtask

    task automatic test_basic(input bit bad_ck);
        do_reset();
        img_words.delete();
        img_words.push_back(32'h3C01_0001);
        img_words.push_back(32'h0000_000C);
        run_image(bad_ck ? "bad_cksum" : "basic", bad_ck, 0);
    endtask

    task automatic test_zero_len();
        do_reset();
        img_words.delete();
        run_image("zero_len", 1'b0, 0);
    endtask

    task automatic test_len_overflow();
        do_reset();
        cap_q.delete();
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        #1;
        n_checks++;
        if ({err, done, cpu_hold, rx_ready} !== 4'b1010) begin
            n_errors++;
            $display("FAIL len_overflow_flags: got %b want 1010", {err, done, cpu_hold, rx_ready});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        idle(3);
        n_checks++;
        if ({err, done, cpu_hold, rx_ready} !== 4'b1010 || cap_q.size() != 0) begin
            n_errors++;
            $display("FAIL len_overflow_ignored: got flags %b writes %0d want 1010 writes 0",
                     {err, done, cpu_hold, rx_ready}, cap_q.size());
        end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            img_words.delete();
            for (int i = 0; i < 3; i++) img_words.push_back($urandom);
            do_reset();
            run_image("gap_free", 1'b0, 0);
            do_reset();
            run_image("gaps", 1'b0, 4);
        end
    endtask

    task automatic test_random();
        int n;
        bit bad;
        for (int r = 0; r < 6; r++) begin
            n   = int'($urandom_range(8, 1));
            bad = 1'($urandom_range(1, 0));
            img_words.delete();
            for (int i = 0; i < n; i++) img_words.push_back($urandom);
            do_reset();
            run_image("random", bad, 2);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] pl[6];
        pl = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(pl[i], 0);
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready, we, cpu_hold, done, err} !== 5'b10100 || waddr !== BASE) begin
            n_errors++;
            $display("FAIL midload_reset: got flags %b waddr %h want 10100 %h",
                     {rx_ready, we, cpu_hold, done, err}, waddr, BASE);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        img_words.delete();
        img_words.push_back(32'hDEAD_BEEF);
        run_image("reload", 1'b0, 0);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        b2b_seen = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_len_overflow();
        test_zero_len();
        test_gaps();
        test_reset_midload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
